// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if : requester-side and memory-side bus of the port arbiter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]             req_avail;
  logic [NUM_REQ-1:0]             req_r_en;
  logic [NUM_REQ-1:0]             req_w_en;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_ptr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_store;
  logic [NUM_REQ-1:0]             req_write_through;
  logic [NUM_REQ-1:0]             req_done;
  logic [DATA_W-1:0]              req_data_load;

  logic                           mem_avail;
  logic                           mem_r_en;
  logic                           mem_w_en;
  logic [ADDR_W-1:0]              mem_ptr;
  logic [DATA_W-1:0]              mem_data_store;
  logic                           mem_write_through;
  logic                           mem_done;
  logic [DATA_W-1:0]              mem_data_load;

  // Arbiter view
  modport master (
    input  req_avail, req_r_en, req_w_en, req_ptr, req_data_store,
           req_write_through, mem_done, mem_data_load,
    output req_done, req_data_load, mem_avail, mem_r_en, mem_w_en,
           mem_ptr, mem_data_store, mem_write_through
  );

  // Requesters plus memory controller view
  modport slave (
    output req_avail, req_r_en, req_w_en, req_ptr, req_data_store,
           req_write_through, mem_done, mem_data_load,
    input  req_done, req_data_load, mem_avail, mem_r_en, mem_w_en,
           mem_ptr, mem_data_store, mem_write_through
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : round-robin sharing of one memory port by NUM_REQ handles
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_l,
  mem_port_arbiter_if.master bus,
  output logic             busy_o,
  output logic [ID_W-1:0]  grant_id_o
);

  localparam int CW = ID_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e              state_q;
  logic [ID_W-1:0]     grant_q;
  logic                mem_avail_q;
  logic                mem_r_en_q;
  logic                mem_w_en_q;
  logic                mem_wt_q;
  logic [ADDR_W-1:0]   mem_ptr_q;
  logic [DATA_W-1:0]   mem_data_q;

  logic [NUM_REQ-1:0]  req_valid;
  logic                any_valid;
  logic [ID_W-1:0]     win_idx;
  logic [CW-1:0]       cand;
  logic [NUM_REQ-1:0]  done_vec;

  assign req_valid = bus.req_avail & (bus.req_r_en | bus.req_w_en);

  // Scan last_grant+1 .. last_grant+NUM_REQ with wrap; first valid wins.
  always_comb begin
    any_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, grant_q} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!any_valid && req_valid[cand[ID_W-1:0]]) begin
        any_valid = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= S_IDLE;
      grant_q     <= ID_W'(NUM_REQ - 1);
      mem_avail_q <= 1'b0;
      mem_r_en_q  <= 1'b0;
      mem_w_en_q  <= 1'b0;
      mem_wt_q    <= 1'b0;
      mem_ptr_q   <= '0;
      mem_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            state_q     <= S_BUSY;
            grant_q     <= win_idx;
            mem_avail_q <= 1'b1;
            // Write takes priority when both enables are set.
            mem_r_en_q  <= bus.req_r_en[win_idx] & ~bus.req_w_en[win_idx];
            mem_w_en_q  <= bus.req_w_en[win_idx];
            mem_wt_q    <= bus.req_write_through[win_idx];
            mem_ptr_q   <= bus.req_ptr[win_idx];
            mem_data_q  <= bus.req_data_store[win_idx];
          end
        end
        S_BUSY: begin
          if (bus.mem_done) begin
            state_q     <= S_RELEASE;
            mem_avail_q <= 1'b0;
            mem_r_en_q  <= 1'b0;
            mem_w_en_q  <= 1'b0;
          end
        end
        S_RELEASE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Completion reaches only the grantee, and only while its command is live.
  always_comb begin
    done_vec = '0;
    if (state_q == S_BUSY && bus.mem_done) begin
      done_vec[grant_q] = 1'b1;
    end
  end

  assign bus.req_done          = done_vec;
  assign bus.req_data_load     = bus.mem_data_load;
  assign bus.mem_avail         = mem_avail_q;
  assign bus.mem_r_en          = mem_r_en_q;
  assign bus.mem_w_en          = mem_w_en_q;
  assign bus.mem_ptr           = mem_ptr_q;
  assign bus.mem_data_store    = mem_data_q;
  assign bus.mem_write_through = mem_wt_q;
  assign busy_o                = (state_q != S_IDLE);
  assign grant_id_o            = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : scoreboard bench for the memory port arbiter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       busy;
  logic [1:0] grant_id;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .bus        (bus),
    .busy_o     (busy),
    .grant_id_o (grant_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_avail         = '0;
    bus.req_r_en          = '0;
    bus.req_w_en          = '0;
    bus.req_ptr           = '0;
    bus.req_data_store    = '0;
    bus.req_write_through = '0;
    bus.mem_done          = 1'b0;
    bus.mem_data_load     = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0h exp 0", busy); end
    checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL rst_grant: got %0d exp 3", grant_id); end
    checks++; if ({bus.mem_avail, bus.mem_r_en, bus.mem_w_en, bus.mem_write_through} !== 4'b0) begin
      failures++; $display("FAIL rst_ctl: got %b exp 0000", {bus.mem_avail, bus.mem_r_en, bus.mem_w_en, bus.mem_write_through}); end
    checks++; if (bus.mem_ptr !== 32'h0 || bus.mem_data_store !== 32'h0) begin
      failures++; $display("FAIL rst_regs: got ptr %0h data %0h exp 0", bus.mem_ptr, bus.mem_data_store); end
    checks++; if (bus.req_done !== 4'b0) begin failures++; $display("FAIL rst_done: got %b exp 0000", bus.req_done); end
    rst_l = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    exp_t e;
    bus.req_avail[2] = 1'b1;
    bus.req_r_en[2]  = 1'b1;
    bus.req_ptr[2]   = 32'h40;
    sb.push_back('{id: 2, data: 32'hDEADBEEF});
    tick();
    checks++; if (bus.mem_avail !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL rd_grant: got avail %0h busy %0h exp 1 1", bus.mem_avail, busy); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL rd_id: got %0d exp 2", grant_id); end
    checks++; if (bus.mem_ptr !== 32'h40 || bus.mem_r_en !== 1'b1 || bus.mem_w_en !== 1'b0) begin
      failures++; $display("FAIL rd_cmd: got ptr %0h r %0h w %0h exp 40 1 0", bus.mem_ptr, bus.mem_r_en, bus.mem_w_en); end
    repeat (3) tick();
    bus.mem_done      = 1'b1;
    bus.mem_data_load = 32'hDEADBEEF;
    bus.req_avail[2]  = 1'b0;
    bus.req_r_en[2]   = 1'b0;
    #1;
    e = sb.pop_front();
    checks++; if (bus.req_done !== (4'b1 << e.id)) begin failures++; $display("FAIL rd_done: got %b exp %b", bus.req_done, 4'b1 << e.id); end
    checks++; if (bus.req_data_load !== e.data) begin failures++; $display("FAIL rd_data: got %0h exp %0h", bus.req_data_load, e.data); end
    tick();
    bus.mem_done = 1'b0;
    checks++; if (bus.mem_avail !== 1'b0 || busy !== 1'b1 || bus.mem_r_en !== 1'b0) begin
      failures++; $display("FAIL rd_release: got avail %0h busy %0h r %0h exp 0 1 0", bus.mem_avail, busy, bus.mem_r_en); end
    checks++; if (bus.mem_ptr !== 32'h40) begin failures++; $display("FAIL rd_ptr_hold: got %0h exp 40", bus.mem_ptr); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_idle: got busy %0h exp 0", busy); end
  endtask

  task automatic test_contention();
    exp_t e;
    int   waited;
    bit   found;
    clear_inputs();
    rst_l = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_avail[i] = 1'b1;
      bus.req_r_en[i]  = 1'b1;
      bus.req_ptr[i]   = 32'h100 + i;
    end
    for (int n = 0; n < 5; n++) sb.push_back('{id: n % NUM_REQ, data: 32'hC0DE_0000 + n});
    tick();
    rst_l = 1'b1;
    for (int n = 0; n < 5; n++) begin
      waited = 0;
      found  = 1'b0;
      while (!found && waited < 8) begin
        tick();
        bus.mem_done = 1'b0;
        waited++;
        if (bus.mem_avail === 1'b1) found = 1'b1;
      end
      checks++; if (!found || waited != ((n == 0) ? 1 : 3)) begin
        failures++; $display("FAIL cont_wait%0d: got %0d cycles exp %0d", n, waited, (n == 0) ? 1 : 3); end
      e = sb.pop_front();
      checks++; if (grant_id !== 2'(e.id)) begin failures++; $display("FAIL cont_id%0d: got %0d exp %0d", n, grant_id, e.id); end
      bus.mem_done      = 1'b1;
      bus.mem_data_load = e.data;
      #1;
      checks++; if (bus.req_done !== (4'b1 << e.id) || bus.req_data_load !== e.data) begin
        failures++; $display("FAIL cont_done%0d: got %b/%0h exp %b/%0h", n, bus.req_done, bus.req_data_load, 4'b1 << e.id, e.data); end
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_write();
    exp_t e;
    bus.req_avail[3]         = 1'b1;
    bus.req_w_en[3]          = 1'b1;
    bus.req_ptr[3]           = 32'h7;
    bus.req_data_store[3]    = 32'h12345678;
    bus.req_write_through[3] = 1'b1;
    sb.push_back('{id: 3, data: 32'h0});
    tick();
    checks++; if (grant_id !== 2'd3 || bus.mem_w_en !== 1'b1 || bus.mem_r_en !== 1'b0) begin
      failures++; $display("FAIL wr_cmd: got id %0d w %0h r %0h exp 3 1 0", grant_id, bus.mem_w_en, bus.mem_r_en); end
    bus.req_data_store[3]    = 32'hFFFF0000;
    bus.req_write_through[3] = 1'b0;
    bus.req_ptr[3]           = 32'h99;
    repeat (2) tick();
    checks++; if (bus.mem_data_store !== 32'h12345678 || bus.mem_write_through !== 1'b1 || bus.mem_ptr !== 32'h7) begin
      failures++; $display("FAIL wr_hold: got %0h wt %0h ptr %0h exp 12345678 1 7", bus.mem_data_store, bus.mem_write_through, bus.mem_ptr); end
    bus.mem_done     = 1'b1;
    bus.req_avail[3] = 1'b0;
    #1;
    e = sb.pop_front();
    checks++; if (bus.req_done !== (4'b1 << e.id)) begin failures++; $display("FAIL wr_done: got %b exp %b", bus.req_done, 4'b1 << e.id); end
    tick();
    bus.mem_done = 1'b0;
    checks++; if (bus.mem_w_en !== 1'b0 || bus.mem_avail !== 1'b0 || bus.mem_data_store !== 32'h12345678) begin
      failures++; $display("FAIL wr_release: got w %0h avail %0h data %0h exp 0 0 12345678", bus.mem_w_en, bus.mem_avail, bus.mem_data_store); end
    clear_inputs();
    tick();
  endtask

  task automatic test_both_en();
    exp_t e;
    bus.req_avail[1] = 1'b1;
    bus.req_r_en[1]  = 1'b1;
    bus.req_w_en[1]  = 1'b1;
    sb.push_back('{id: 1, data: 32'h0});
    tick();
    checks++; if (grant_id !== 2'd1 || bus.mem_w_en !== 1'b1 || bus.mem_r_en !== 1'b0) begin
      failures++; $display("FAIL both_cmd: got id %0d w %0h r %0h exp 1 1 0", grant_id, bus.mem_w_en, bus.mem_r_en); end
    bus.mem_done     = 1'b1;
    bus.req_avail[1] = 1'b0;
    #1;
    e = sb.pop_front();
    checks++; if (bus.req_done !== (4'b1 << e.id)) begin failures++; $display("FAIL both_done: got %b exp %b", bus.req_done, 4'b1 << e.id); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_spurious();
    exp_t e;
    clear_inputs();
    bus.mem_done = 1'b1;
    #1;
    checks++; if (bus.req_done !== 4'b0) begin failures++; $display("FAIL sp_idle_done: got %b exp 0000", bus.req_done); end
    tick();
    checks++; if (busy !== 1'b0 || bus.mem_avail !== 1'b0) begin
      failures++; $display("FAIL sp_idle_state: got busy %0h avail %0h exp 0 0", busy, bus.mem_avail); end
    bus.mem_done     = 1'b0;
    bus.req_avail[0] = 1'b1;
    bus.req_r_en[0]  = 1'b1;
    sb.push_back('{id: 0, data: 32'h55});
    tick();
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin failures++; $display("FAIL sp_grant: got busy %0h id %0d exp 1 0", busy, grant_id); end
    bus.mem_done      = 1'b1;
    bus.mem_data_load = 32'h55;
    bus.req_avail[0]  = 1'b0;
    #1;
    e = sb.pop_front();
    checks++; if (bus.req_done !== (4'b1 << e.id) || bus.req_data_load !== e.data) begin
      failures++; $display("FAIL sp_done: got %b/%0h exp %b/%0h", bus.req_done, bus.req_data_load, 4'b1 << e.id, e.data); end
    tick();
    #1;
    checks++; if (bus.req_done !== 4'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL sp_release: got done %b busy %0h exp 0000 1", bus.req_done, busy); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sp_back_idle: got busy %0h exp 0", busy); end
    bus.mem_done = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sp_stay_idle: got busy %0h exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    clear_inputs();
    bus.req_avail[2] = 1'b1;
    bus.req_r_en[2]  = 1'b1;
    tick();
    checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin failures++; $display("FAIL rm_grant: got busy %0h id %0d exp 1 2", busy, grant_id); end
    tick();
    rst_l        = 1'b0;
    bus.mem_done = 1'b1;
    #1;
    checks++; if (bus.mem_avail !== 1'b0 || busy !== 1'b0 || bus.req_done !== 4'b0) begin
      failures++; $display("FAIL rm_abort: got avail %0h busy %0h done %b exp 0 0 0000", bus.mem_avail, busy, bus.req_done); end
    checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL rm_grant_rst: got %0d exp 3", grant_id); end
    bus.mem_done     = 1'b0;
    bus.req_avail[0] = 1'b1;
    bus.req_r_en[0]  = 1'b1;
    sb.push_back('{id: 0, data: 32'hA5A5});
    tick();
    rst_l = 1'b1;
    tick();
    checks++; if (grant_id !== 2'd0 || bus.mem_avail !== 1'b1) begin
      failures++; $display("FAIL rm_regrant: got id %0d avail %0h exp 0 1", grant_id, bus.mem_avail); end
    bus.mem_done      = 1'b1;
    bus.mem_data_load = 32'hA5A5;
    bus.req_avail     = '0;
    #1;
    e = sb.pop_front();
    checks++; if (bus.req_done !== (4'b1 << e.id) || bus.req_data_load !== e.data) begin
      failures++; $display("FAIL rm_done: got %b/%0h exp %b/%0h", bus.req_done, bus.req_data_load, 4'b1 << e.id, e.data); end
    tick();
    clear_inputs();
    tick();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_empty: got %0d left exp 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_both_en();
    test_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
